// File: rtl/bus_arbiter2_if.sv
// Bus bundle for the two-master / one-target arbiter: both master ports,
// the shared target port and the grant vector.
interface bus_arbiter2_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
);
  localparam int unsigned SWIDTH = DWIDTH / 8;

  logic              m0_cyc_i;
  logic              m0_stb_i;
  logic              m0_we_i;
  logic [SWIDTH-1:0] m0_sel_i;
  logic [AWIDTH-1:0] m0_adr_i;
  logic [DWIDTH-1:0] m0_dat_i;
  logic [DWIDTH-1:0] m0_dat_o;
  logic              m0_ack_o;
  logic              m0_err_o;

  logic              m1_cyc_i;
  logic              m1_stb_i;
  logic              m1_we_i;
  logic [SWIDTH-1:0] m1_sel_i;
  logic [AWIDTH-1:0] m1_adr_i;
  logic [DWIDTH-1:0] m1_dat_i;
  logic [DWIDTH-1:0] m1_dat_o;
  logic              m1_ack_o;
  logic              m1_err_o;

  logic              s_cyc_o;
  logic              s_stb_o;
  logic              s_we_o;
  logic [SWIDTH-1:0] s_sel_o;
  logic [AWIDTH-1:0] s_adr_o;
  logic [DWIDTH-1:0] s_dat_o;
  logic [DWIDTH-1:0] s_dat_i;
  logic              s_ack_i;

  logic [1:0]        gnt_o;

  // Arbiter view
  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i,
    output gnt_o
  );

  // Environment view: drives the masters and the target response
  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i,
    input  gnt_o
  );
endinterface

// File: rtl/bus_arbiter2.sv
// Two-master Wishbone-classic arbiter: tenure-long grants, round-robin on
// ties, and a no-ack timeout that returns err to a stalled owner.
module bus_arbiter2 #(
  parameter int unsigned AWIDTH  = 32,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  bus_arbiter2_if.slave    bus
);
  localparam int unsigned SWIDTH = DWIDTH / 8;
  localparam int unsigned TMAX   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int unsigned CW     = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state;
  logic [1:0]    gnt;
  logic          last;
  logic [CW-1:0] cnt;
  logic          err0;
  logic          err1;

  // Grant FSM, timeout counter and registered error pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      gnt   <= 2'b00;
      last  <= 1'b1;
      cnt   <= '0;
      err0  <= 1'b0;
      err1  <= 1'b0;
    end else begin
      err0 <= 1'b0;
      err1 <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          // On a tie the master that did not own the bus last wins
          if (bus.m0_cyc_i && (!bus.m1_cyc_i || last)) begin
            state <= GNT0;
            gnt   <= 2'b01;
          end else if (bus.m1_cyc_i) begin
            state <= GNT1;
            gnt   <= 2'b10;
          end
        end
        GNT0: begin
          if (!bus.m0_cyc_i) begin
            last <= 1'b0;
            cnt  <= '0;
            if (bus.m1_cyc_i) begin
              state <= GNT1;
              gnt   <= 2'b10;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end else if (TIMEOUT != 0) begin
            if (bus.s_ack_i || !bus.m0_stb_i) begin
              cnt <= '0;
            end else if (cnt == CW'(TMAX)) begin
              cnt  <= '0;
              err0 <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        GNT1: begin
          if (!bus.m1_cyc_i) begin
            last <= 1'b1;
            cnt  <= '0;
            if (bus.m0_cyc_i) begin
              state <= GNT0;
              gnt   <= 2'b01;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end else if (TIMEOUT != 0) begin
            if (bus.s_ack_i || !bus.m1_stb_i) begin
              cnt <= '0;
            end else if (cnt == CW'(TMAX)) begin
              cnt  <= '0;
              err1 <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Target-side mux and ack return path follow the current grant
  always_comb begin
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.s_we_o   = 1'b0;
    bus.s_sel_o  = SWIDTH'(0);
    bus.s_adr_o  = AWIDTH'(0);
    bus.s_dat_o  = DWIDTH'(0);
    bus.m0_ack_o = 1'b0;
    bus.m1_ack_o = 1'b0;
    case (state)
      GNT0: begin
        bus.s_cyc_o  = bus.m0_cyc_i;
        bus.s_stb_o  = bus.m0_stb_i;
        bus.s_we_o   = bus.m0_we_i;
        bus.s_sel_o  = bus.m0_sel_i;
        bus.s_adr_o  = bus.m0_adr_i;
        bus.s_dat_o  = bus.m0_dat_i;
        bus.m0_ack_o = bus.s_ack_i;
      end
      GNT1: begin
        bus.s_cyc_o  = bus.m1_cyc_i;
        bus.s_stb_o  = bus.m1_stb_i;
        bus.s_we_o   = bus.m1_we_i;
        bus.s_sel_o  = bus.m1_sel_i;
        bus.s_adr_o  = bus.m1_adr_i;
        bus.s_dat_o  = bus.m1_dat_i;
        bus.m1_ack_o = bus.s_ack_i;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; masters qualify it with their own ack
  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;
  assign bus.m0_err_o = err0;
  assign bus.m1_err_o = err1;
  assign bus.gnt_o    = gnt;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Scoreboard bench for bus_arbiter2: the driver queues the expected bus
// picture for each cycle, a negedge monitor pops and compares it.
module tb_bus_arbiter2;
  typedef logic [140:0] vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  vec_t  exp_q[$];
  string name_q[$];
  vec_t  mon_exp;
  vec_t  mon_act;
  string mon_name;

  bus_arbiter2_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  bus_arbiter2 #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t pack(input logic [1:0] g, input logic cyc, input logic stb,
                                input logic we, input logic [3:0] sel, input logic [31:0] adr,
                                input logic [31:0] dat, input logic [1:0] ack, input logic [1:0] err,
                                input logic [31:0] d0, input logic [31:0] d1);
    return {g, cyc, stb, we, sel, adr, dat, ack, err, d0, d1};
  endfunction

  // Monitor: compare whatever the driver queued for this cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = pack(bus.gnt_o, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o,
                      bus.s_adr_o, bus.s_dat_o, {bus.m1_ack_o, bus.m0_ack_o},
                      {bus.m1_err_o, bus.m0_err_o}, bus.m0_dat_o, bus.m1_dat_o);
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", mon_name, mon_act, mon_exp);
      end
    end
  end

  task automatic set_m0(input logic c, input logic s, input logic w, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat);
    bus.m0_cyc_i = c; bus.m0_stb_i = s; bus.m0_we_i = w;
    bus.m0_sel_i = sel; bus.m0_adr_i = adr; bus.m0_dat_i = dat;
  endtask

  task automatic set_m1(input logic c, input logic s, input logic w, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat);
    bus.m1_cyc_i = c; bus.m1_stb_i = s; bus.m1_we_i = w;
    bus.m1_sel_i = sel; bus.m1_adr_i = adr; bus.m1_dat_i = dat;
  endtask

  // Queue the expected picture for this cycle (target side follows grant g), then advance
  task automatic tick(input string nm, input logic [1:0] g, input logic [1:0] ack,
                      input logic [1:0] err);
    vec_t e;
    case (g)
      2'b01: e = pack(g, bus.m0_cyc_i, bus.m0_stb_i, bus.m0_we_i, bus.m0_sel_i, bus.m0_adr_i,
                      bus.m0_dat_i, ack, err, bus.s_dat_i, bus.s_dat_i);
      2'b10: e = pack(g, bus.m1_cyc_i, bus.m1_stb_i, bus.m1_we_i, bus.m1_sel_i, bus.m1_adr_i,
                      bus.m1_dat_i, ack, err, bus.s_dat_i, bus.s_dat_i);
      default: e = pack(g, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, ack, err,
                        bus.s_dat_i, bus.s_dat_i);
    endcase
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    bus.s_dat_i = bus.s_dat_i + 32'h0101_0101;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
    set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = 32'h1234_0000;
    @(posedge clk);
    #1;

    // Reset and idle
    tick("reset_hold", 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    tick("idle0", 2'b00, 2'b00, 2'b00);
    tick("idle1", 2'b00, 2'b00, 2'b00);

    // m1 alone, four acked beats
    set_m1(1, 1, 0, 4'hF, 32'h100, 32'h0);
    tick("m1_req", 2'b00, 2'b00, 2'b00);
    bus.s_ack_i = 1'b1;
    tick("m1_beat0", 2'b10, 2'b10, 2'b00);
    bus.m1_adr_i = 32'h104;
    tick("m1_beat1", 2'b10, 2'b10, 2'b00);
    bus.m1_adr_i = 32'h108;
    tick("m1_beat2", 2'b10, 2'b10, 2'b00);
    bus.m1_adr_i = 32'h10C;
    tick("m1_beat3", 2'b10, 2'b10, 2'b00);
    set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    tick("m1_drop", 2'b10, 2'b00, 2'b00);
    tick("m1_idle", 2'b00, 2'b00, 2'b00);

    // Simultaneous request after reset: m0 first, then m1 with no idle gap
    rst = 1'b1;
    tick("rst2", 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    set_m0(1, 1, 0, 4'hF, 32'h200, 32'h0);
    set_m1(1, 1, 0, 4'hF, 32'h300, 32'h0);
    tick("tie_req", 2'b00, 2'b00, 2'b00);
    bus.s_ack_i = 1'b1;
    tick("tie_g0", 2'b01, 2'b01, 2'b00);
    set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    tick("tie_m0drop", 2'b01, 2'b00, 2'b00);
    bus.s_ack_i = 1'b1;
    tick("tie_g1", 2'b10, 2'b10, 2'b00);
    set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    tick("tie_m1drop", 2'b10, 2'b00, 2'b00);
    tick("tie_idle", 2'b00, 2'b00, 2'b00);

    // Back-to-back contention: grants alternate 0,1,0,1
    set_m0(1, 1, 0, 4'hF, 32'h400, 32'h0);
    set_m1(1, 1, 0, 4'hF, 32'h500, 32'h0);
    tick("rr_req", 2'b00, 2'b00, 2'b00);
    bus.s_ack_i = 1'b1;
    tick("rr0", 2'b01, 2'b01, 2'b00);
    set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    tick("rr0_drop", 2'b01, 2'b00, 2'b00);
    set_m0(1, 1, 0, 4'hF, 32'h404, 32'h0);
    bus.s_ack_i = 1'b1;
    tick("rr1", 2'b10, 2'b10, 2'b00);
    set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    tick("rr1_drop", 2'b10, 2'b00, 2'b00);
    set_m1(1, 1, 0, 4'hF, 32'h504, 32'h0);
    bus.s_ack_i = 1'b1;
    tick("rr2", 2'b01, 2'b01, 2'b00);
    set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    tick("rr2_drop", 2'b01, 2'b00, 2'b00);
    bus.s_ack_i = 1'b1;
    tick("rr3", 2'b10, 2'b10, 2'b00);
    set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    tick("rr3_drop", 2'b10, 2'b00, 2'b00);
    tick("rr_idle", 2'b00, 2'b00, 2'b00);

    // Timeout: 8 stalled cycles then a one-cycle err, grant kept
    set_m0(1, 1, 0, 4'hF, 32'h600, 32'h0);
    tick("to_req", 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 8; i++) tick("to_stall", 2'b01, 2'b00, 2'b00);
    tick("to_err", 2'b01, 2'b00, 2'b01);
    tick("to_after", 2'b01, 2'b00, 2'b00);
    set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
    tick("to_drop", 2'b01, 2'b00, 2'b00);
    tick("to_idle", 2'b00, 2'b00, 2'b00);

    // Ack on the eighth stalled cycle wins over the timeout
    set_m0(1, 1, 0, 4'hF, 32'h610, 32'h0);
    tick("ta_req", 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 7; i++) tick("ta_stall", 2'b01, 2'b00, 2'b00);
    bus.s_ack_i = 1'b1;
    tick("ta_ack", 2'b01, 2'b01, 2'b00);
    set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    tick("ta_drop_noerr", 2'b01, 2'b00, 2'b00);
    tick("ta_idle", 2'b00, 2'b00, 2'b00);

    // m1 write holds the target while m0 waits, then m0 gets its own values through
    set_m1(1, 1, 1, 4'hF, 32'h700, 32'hDEADBEEF);
    tick("wr_req", 2'b00, 2'b00, 2'b00);
    set_m0(1, 1, 0, 4'h3, 32'h800, 32'hCAFEF00D);
    tick("wr_stall0", 2'b10, 2'b00, 2'b00);
    tick("wr_stall1", 2'b10, 2'b00, 2'b00);
    bus.s_ack_i = 1'b1;
    tick("wr_ack", 2'b10, 2'b10, 2'b00);
    set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    tick("wr_m1drop", 2'b10, 2'b00, 2'b00);
    bus.s_ack_i = 1'b1;
    tick("wr_g0", 2'b01, 2'b01, 2'b00);
    set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    tick("wr_m0drop", 2'b01, 2'b00, 2'b00);
    tick("wr_idle", 2'b00, 2'b00, 2'b00);

    // Reset mid-GNT1: target side drops within the same cycle, ack ignored
    set_m1(1, 1, 0, 4'hF, 32'h900, 32'h0);
    tick("rm_req", 2'b00, 2'b00, 2'b00);
    tick("rm_g1", 2'b10, 2'b00, 2'b00);
    rst = 1'b1;
    bus.s_ack_i = 1'b1;
    tick("rm_rst", 2'b00, 2'b00, 2'b00);
    set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0);
    bus.s_ack_i = 1'b0;
    tick("rm_rst_hold", 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    tick("rm_idle", 2'b00, 2'b00, 2'b00);

    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_arbiter2.md
Name: bus_arbiter2

Overview:
- Two-master, one-target bus arbiter sharing a single memory port (ram2 port) between the data-access master (m0) and the instruction fetch unit (m1).
- Wishbone-classic style: grant is held for the full cyc_i tenure of the owner; round-robin on ties.
- Includes a no-ack timeout that returns err to the stalled master so a dead target cannot hang the pipeline.

Parameters:
- AWIDTH, 32, address width of master and target address buses.
- DWIDTH, 32, data width; sel width is DWIDTH/8.
- TIMEOUT, 255, cycles of stb without ack before err is asserted; 0 disables the timeout.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle, strobe and write enable.
- m0_sel_i  in  DWIDTH/8  master 0 byte selects.
- m0_adr_i  in  AWIDTH  master 0 address.
- m0_dat_i  in  DWIDTH  master 0 write data.
- m0_dat_o  out  DWIDTH  master 0 read data.
- m0_ack_o, m0_err_o  out  1 each  master 0 ack and timeout error.
- m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i, m1_dat_o, m1_ack_o, m1_err_o: same as m0, for master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  target cycle, strobe and write enable.
- s_sel_o  out  DWIDTH/8  target byte selects.
- s_adr_o  out  AWIDTH  target address.
- s_dat_o  out  DWIDTH  target write data.
- s_dat_i  in  DWIDTH  target read data.
- s_ack_i  in  1  target ack.
- gnt_o  out  2  one-hot current grant; 00 when idle.

Behaviour:
- State machine: IDLE, GNT0, GNT1, registered.
- Reset (async, any time, including mid-transfer):
  - state=IDLE, last=1, timeout counter=0, all err=0.
  - Outputs go to idle values immediately: s_cyc_o=0, s_stb_o=0, s_we_o=0, s_sel_o=0, s_adr_o=0, s_dat_o=0, gnt_o=00, m*_ack_o=0, m*_err_o=0.
- IDLE transitions:
  - only m0_cyc_i -> GNT0.
  - only m1_cyc_i -> GNT1.
  - both -> grant the master != last (m0 wins the first tie after reset).
  - neither -> stay IDLE.
- GNTn:
  - Hold while mn_cyc_i=1; the other master's requests are ignored.
  - When mn_cyc_i falls: go directly to GNTm if the other master's cyc_i=1 (no idle bubble), else IDLE.
  - last<=n on leaving GNTn.
- Latency: a grant appears one clock after cyc_i is first sampled high. Target-side outputs are combinational muxes of the granted master's signals.
- Target outputs: s_cyc_o = granted cyc_i, s_stb_o = granted stb_i. In IDLE, all target outputs are 0.
- Return path:
  - s_ack_i is routed combinationally to the granted master's ack_o only; the other ack_o=0.
  - s_dat_i is broadcast to both dat_o (qualify with ack).
  - s_ack_i while IDLE is ignored.
- Timeout (TIMEOUT>0):
  - Counter increments each cycle in GNTn with stb=1 and s_ack_i=0; it clears on ack, on grant change and in IDLE.
  - When the counter reaches TIMEOUT: mn_err_o=1 for exactly one cycle (registered), the counter clears, and the grant is kept until cyc drops.
  - s_ack_i in the same cycle the count would reach TIMEOUT wins: ack is delivered, no err.
- Master rules: a master keeps adr/we/sel/dat stable while stb=1 and not acked. Pipelined ifetch may hold cyc across many acks; this is not interrupted (no preemption).
- gnt_o is registered, equal to the state one-hot.

Test Plan:
- Reset, no requests -> gnt_o=00, s_cyc_o=0, all acks/errs 0. Assert rst_i mid-GNT1 -> s_cyc_o drops the same cycle; state IDLE.
- m1 alone, cyc for 4 acks at adr 0x100..0x10C -> gnt_o=10 one cycle after cyc; m1_ack_o mirrors s_ack_i four times; m0_ack_o stays 0.
- m0 and m1 raise cyc the same cycle after reset -> GNT0 first; when m0 drops cyc, GNT1 on the next edge with no IDLE cycle.
- Back-to-back ties (both cyc continuously, each drops after 1 ack) -> grants alternate 0,1,0,1.
- m0 holds stb with s_ack_i=0, TIMEOUT=8 -> m0_err_o high for one cycle after 8 stalled cycles; ack on cycle 8 instead -> no err.
- m1 write, we=1, sel=0xF, dat=0xDEADBEEF, while m0 requests -> s_* carry m1 values unchanged until m1 cyc falls; m0 is then granted with its own adr/dat.
